// File: rtl/tex_coord_if.sv
// Quad handshake bundle for tex_coord_unit: interpolator-side input and ROP-side output.
interface tex_coord_if #(
  parameter int unsigned COORD_W = 32
);
  logic                      in_valid;
  logic                      in_ready;
  logic [31:0]               in_x;
  logic [31:0]               in_y;
  logic [3:0]                in_mask;
  logic [31:0]               in_const_color_argb;
  logic signed [COORD_W-1:0] in_bary_w0;
  logic signed [COORD_W-1:0] in_bary_w1;
  logic signed [COORD_W-1:0] in_bary_w2;
  logic signed [COORD_W-1:0] in_tri_area;
  logic signed [COORD_W-1:0] in_v0_u;
  logic signed [COORD_W-1:0] in_v0_v;
  logic signed [COORD_W-1:0] in_v1_u;
  logic signed [COORD_W-1:0] in_v1_v;
  logic signed [COORD_W-1:0] in_v2_u;
  logic signed [COORD_W-1:0] in_v2_v;
  logic                      in_tex_enable;
  logic [31:0]               in_tex_base;
  logic [31:0]               in_tex_stride_bytes;
  logic [15:0]               in_tex_width;
  logic [15:0]               in_tex_height;
  logic [1:0]                in_tex_format;
  logic [1:0]                in_wrap_u;
  logic [1:0]                in_wrap_v;

  logic                      out_valid;
  logic                      out_ready;
  logic [31:0]               out_x;
  logic [31:0]               out_y;
  logic [3:0]                out_mask;
  logic [31:0]               out_const_color_argb;
  logic                      out_tex_enable;
  logic [15:0]               out_u;
  logic [15:0]               out_v;
  logic [31:0]               out_tex_addr;

  modport master (
    output in_valid, in_x, in_y, in_mask, in_const_color_argb,
           in_bary_w0, in_bary_w1, in_bary_w2, in_tri_area,
           in_v0_u, in_v0_v, in_v1_u, in_v1_v, in_v2_u, in_v2_v,
           in_tex_enable, in_tex_base, in_tex_stride_bytes,
           in_tex_width, in_tex_height, in_tex_format, in_wrap_u, in_wrap_v,
           out_ready,
    input  in_ready, out_valid, out_x, out_y, out_mask, out_const_color_argb,
           out_tex_enable, out_u, out_v, out_tex_addr
  );

  modport slave (
    input  in_valid, in_x, in_y, in_mask, in_const_color_argb,
           in_bary_w0, in_bary_w1, in_bary_w2, in_tri_area,
           in_v0_u, in_v0_v, in_v1_u, in_v1_v, in_v2_u, in_v2_v,
           in_tex_enable, in_tex_base, in_tex_stride_bytes,
           in_tex_width, in_tex_height, in_tex_format, in_wrap_u, in_wrap_v,
           out_ready,
    output in_ready, out_valid, out_x, out_y, out_mask, out_const_color_argb,
           out_tex_enable, out_u, out_v, out_tex_addr
  );
endinterface

// File: rtl/tex_coord_unit.sv
// Texture coordinate unit: barycentric u/v interpolation, shared iterative divide, wrap, texel address.
// Define TEX_MIRROR_EN to enable mirror wrap (mode 2); otherwise mode 2 behaves as clamp.
module tex_coord_unit #(
  parameter int unsigned COORD_W = 32,
  parameter int unsigned QUOT_W  = 16,
  parameter int unsigned ACC_W   = 2*COORD_W+2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flush,
  output logic       busy,
  tex_coord_if.slave bus
);
  localparam int unsigned PROD_W = 2*COORD_W;
  localparam int unsigned CNT_W  = $clog2(QUOT_W);

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_ACC, S_DIV, S_ADDR, S_HOLD} state_t;

  state_t state_q, state_d;

  logic [31:0]               x_q, y_q, color_q, base_q, stride_q;
  logic [3:0]                mask_q;
  logic                      tex_en_q;
  logic [15:0]               width_q, height_q;
  logic [1:0]                fmt_q, wrap_u_q, wrap_v_q;
  logic signed [COORD_W-1:0] area_q;
  logic signed [COORD_W-1:0] w_q  [3];
  logic signed [COORD_W-1:0] tu_q [3];
  logic signed [COORD_W-1:0] tv_q [3];
  logic signed [PROD_W-1:0]  pu_q [3];
  logic signed [PROD_W-1:0]  pv_q [3];

  logic [ACC_W-1:0]  rem_u_q, rem_v_q, dsh_q;
  logic [QUOT_W-1:0] q_u_q, q_v_q;
  logic              neg_u_q, neg_v_q, sat_u_q, sat_v_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              addr_ph_q;
  logic [15:0]       wu_q, wv_q;

  logic signed [ACC_W-1:0]  acc_u_c, acc_v_c, area_ext_c;
  logic [ACC_W-1:0]         mag_u_c, mag_v_c, mag_area_c;
  logic                     area_zero_c, ge_u_c, ge_v_c;
  logic signed [QUOT_W-1:0] cu_c, cv_c;
  logic [1:0]               shift_c;
  logic [31:0]              addr_c;

  // Wrap a signed texel coordinate into [0, d) according to the axis mode.
  function automatic logic [15:0] wrap_coord(input logic signed [QUOT_W-1:0] c,
                                             input logic [15:0] d,
                                             input logic [1:0] mode);
    logic signed [33:0] cs, ds;
    logic [15:0]        r;
`ifdef TEX_MIRROR_EN
    logic signed [33:0] m, span;
`endif
    cs = 34'(c);
    ds = 34'(d);
    r  = '0;
`ifdef TEX_MIRROR_EN
    span = (ds <<< 1) - 34'sd1;
    m    = cs & span;
`endif
    if (d == 16'd0) begin
      r = '0;
    end else if (mode == 2'd1) begin
      r = 16'(cs & (ds - 34'sd1));
`ifdef TEX_MIRROR_EN
    end else if (mode == 2'd2) begin
      r = (m >= ds) ? 16'(span - m) : 16'(m);
`endif
    end else if (cs[33]) begin
      r = '0;
    end else if (cs >= ds) begin
      r = 16'(ds - 34'sd1);
    end else begin
      r = 16'(cs);
    end
    return r;
  endfunction

  // Accumulation, magnitudes and divider step decisions.
  always_comb begin
    acc_u_c     = ACC_W'(pu_q[0]) + ACC_W'(pu_q[1]) + ACC_W'(pu_q[2]);
    acc_v_c     = ACC_W'(pv_q[0]) + ACC_W'(pv_q[1]) + ACC_W'(pv_q[2]);
    area_ext_c  = ACC_W'(area_q);
    mag_u_c     = acc_u_c[ACC_W-1]    ? ({ACC_W{1'b0}} - acc_u_c)    : acc_u_c;
    mag_v_c     = acc_v_c[ACC_W-1]    ? ({ACC_W{1'b0}} - acc_v_c)    : acc_v_c;
    mag_area_c  = area_ext_c[ACC_W-1] ? ({ACC_W{1'b0}} - area_ext_c) : area_ext_c;
    area_zero_c = (area_q == '0);
    ge_u_c      = (rem_u_q >= dsh_q);
    ge_v_c      = (rem_v_q >= dsh_q);
  end

  // Signed quotient with saturation, and the final byte address.
  always_comb begin
    cu_c = sat_u_q ? (neg_u_q ? {1'b1, {(QUOT_W-1){1'b0}}} : {1'b0, {(QUOT_W-1){1'b1}}})
                   : (neg_u_q ? ({QUOT_W{1'b0}} - q_u_q) : q_u_q);
    cv_c = sat_v_q ? (neg_v_q ? {1'b1, {(QUOT_W-1){1'b0}}} : {1'b0, {(QUOT_W-1){1'b1}}})
                   : (neg_v_q ? ({QUOT_W{1'b0}} - q_v_q) : q_v_q);
    unique case (fmt_q)
      2'd1:    shift_c = 2'd1;
      2'd2:    shift_c = 2'd0;
      default: shift_c = 2'd2;
    endcase
    addr_c = tex_en_q ? (base_q + 32'(wv_q) * stride_q + (32'(wu_q) << shift_c)) : 32'd0;
  end

  // Next-state logic; flush overrides everything, including a pending capture.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (bus.in_valid) state_d = S_MUL;
      S_MUL:  state_d = S_ACC;
      S_ACC:  state_d = area_zero_c ? S_ADDR : S_DIV;
      S_DIV:  if (cnt_q == CNT_W'(QUOT_W-1)) state_d = S_ADDR;
      S_ADDR: if (addr_ph_q) state_d = S_HOLD;
      S_HOLD: if (bus.out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (flush) state_d = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q                  <= S_IDLE;
      busy                     <= 1'b0;
      bus.in_ready             <= 1'b1;
      bus.out_valid            <= 1'b0;
      bus.out_x                <= '0;
      bus.out_y                <= '0;
      bus.out_mask             <= '0;
      bus.out_const_color_argb <= '0;
      bus.out_tex_enable       <= 1'b0;
      bus.out_u                <= '0;
      bus.out_v                <= '0;
      bus.out_tex_addr         <= '0;
      x_q <= '0; y_q <= '0; color_q <= '0; base_q <= '0; stride_q <= '0;
      mask_q <= '0; tex_en_q <= 1'b0; width_q <= '0; height_q <= '0;
      fmt_q <= '0; wrap_u_q <= '0; wrap_v_q <= '0; area_q <= '0;
      for (int i = 0; i < 3; i++) begin
        w_q[i] <= '0; tu_q[i] <= '0; tv_q[i] <= '0; pu_q[i] <= '0; pv_q[i] <= '0;
      end
      rem_u_q <= '0; rem_v_q <= '0; dsh_q <= '0; q_u_q <= '0; q_v_q <= '0;
      neg_u_q <= 1'b0; neg_v_q <= 1'b0; sat_u_q <= 1'b0; sat_v_q <= 1'b0;
      cnt_q <= '0; addr_ph_q <= 1'b0; wu_q <= '0; wv_q <= '0;
    end else begin
      state_q       <= state_d;
      busy          <= (state_d != S_IDLE);
      bus.in_ready  <= (state_d == S_IDLE);
      bus.out_valid <= (state_d == S_HOLD);
      unique case (state_q)
        S_IDLE: if (bus.in_valid && !flush) begin
          x_q      <= bus.in_x;          y_q      <= bus.in_y;
          mask_q   <= bus.in_mask;       color_q  <= bus.in_const_color_argb;
          w_q[0]   <= bus.in_bary_w0;    w_q[1]   <= bus.in_bary_w1;
          w_q[2]   <= bus.in_bary_w2;    area_q   <= bus.in_tri_area;
          tu_q[0]  <= bus.in_v0_u;       tv_q[0]  <= bus.in_v0_v;
          tu_q[1]  <= bus.in_v1_u;       tv_q[1]  <= bus.in_v1_v;
          tu_q[2]  <= bus.in_v2_u;       tv_q[2]  <= bus.in_v2_v;
          tex_en_q <= bus.in_tex_enable; base_q   <= bus.in_tex_base;
          stride_q <= bus.in_tex_stride_bytes;
          width_q  <= bus.in_tex_width;  height_q <= bus.in_tex_height;
          fmt_q    <= bus.in_tex_format;
          wrap_u_q <= bus.in_wrap_u;     wrap_v_q <= bus.in_wrap_v;
        end
        S_MUL: begin
          for (int i = 0; i < 3; i++) begin
            pu_q[i] <= PROD_W'(w_q[i]) * PROD_W'(tu_q[i]);
            pv_q[i] <= PROD_W'(w_q[i]) * PROD_W'(tv_q[i]);
          end
        end
        S_ACC: begin
          neg_u_q   <= acc_u_c[ACC_W-1] ^ area_q[COORD_W-1];
          neg_v_q   <= acc_v_c[ACC_W-1] ^ area_q[COORD_W-1];
          sat_u_q   <= !area_zero_c && (mag_u_c >= (mag_area_c << QUOT_W));
          sat_v_q   <= !area_zero_c && (mag_v_c >= (mag_area_c << QUOT_W));
          rem_u_q   <= mag_u_c;
          rem_v_q   <= mag_v_c;
          dsh_q     <= mag_area_c << (QUOT_W-1);
          q_u_q     <= '0;
          q_v_q     <= '0;
          cnt_q     <= '0;
          addr_ph_q <= 1'b0;
        end
        // Restoring divide: one quotient bit per cycle against a right-shifting divisor.
        S_DIV: begin
          if (ge_u_c) rem_u_q <= rem_u_q - dsh_q;
          if (ge_v_c) rem_v_q <= rem_v_q - dsh_q;
          q_u_q <= {q_u_q[QUOT_W-2:0], ge_u_c};
          q_v_q <= {q_v_q[QUOT_W-2:0], ge_v_c};
          dsh_q <= dsh_q >> 1;
          cnt_q <= cnt_q + CNT_W'(1);
        end
        S_ADDR: begin
          addr_ph_q <= 1'b1;
          if (!addr_ph_q) begin
            wu_q <= wrap_coord(cu_c, width_q, wrap_u_q);
            wv_q <= wrap_coord(cv_c, height_q, wrap_v_q);
          end else begin
            bus.out_x                <= x_q;
            bus.out_y                <= y_q;
            bus.out_mask             <= mask_q;
            bus.out_const_color_argb <= color_q;
            bus.out_tex_enable       <= tex_en_q;
            bus.out_u                <= wu_q;
            bus.out_v                <= wv_q;
            bus.out_tex_addr         <= addr_c;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_tex_coord_unit.sv
// Directed bench for tex_coord_unit: hand-computed quads, wrap modes, latency, hold, flush and reset.
module tb_tex_coord_unit;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic busy;
  int   n_checks = 0;
  int   n_errors = 0;
  int   lat;

  always #5 clk = ~clk;

  tex_coord_if #(.COORD_W(32)) bus ();

  tex_coord_unit #(.COORD_W(32), .QUOT_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .busy  (busy),
    .bus   (bus.slave)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_inputs();
    bus.in_valid = 1'b0;          bus.out_ready = 1'b0;
    bus.in_x = 32'h0;             bus.in_y = 32'h0;
    bus.in_mask = 4'h0;           bus.in_const_color_argb = 32'h0;
    bus.in_bary_w0 = 0;           bus.in_bary_w1 = 0;         bus.in_bary_w2 = 0;
    bus.in_tri_area = 0;
    bus.in_v0_u = 0; bus.in_v0_v = 0; bus.in_v1_u = 0;
    bus.in_v1_v = 0; bus.in_v2_u = 0; bus.in_v2_v = 0;
    bus.in_tex_enable = 1'b1;     bus.in_tex_base = 32'h0;
    bus.in_tex_stride_bytes = 32'h0;
    bus.in_tex_width = 16'd0;     bus.in_tex_height = 16'd0;
    bus.in_tex_format = 2'd0;     bus.in_wrap_u = 2'd0;       bus.in_wrap_v = 2'd0;
  endtask

  // Called just after a negedge with the DUT idle; returns edges from accept to out_valid.
  task automatic accept_and_wait(output int edges);
    check("in_ready_idle", 64'(bus.in_ready), 64'd1);
    bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("busy_after_accept", 64'(busy), 64'd1);
    edges = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (bus.out_valid) break;
    end
    if (!bus.out_valid) check("out_valid_timeout", 64'd0, 64'd1);
  endtask

  task automatic release_out();
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("out_valid_after_release", 64'(bus.out_valid), 64'd0);
    check("in_ready_after_release", 64'(bus.in_ready), 64'd1);
  endtask

  task automatic run_quad(input string tag, input logic [15:0] eu, input logic [15:0] ev,
                          input logic [31:0] eaddr, input int elat);
    accept_and_wait(lat);
    check({tag, "_lat"}, 64'(lat), 64'(elat));
    check({tag, "_u"}, 64'(bus.out_u), 64'(eu));
    check({tag, "_v"}, 64'(bus.out_v), 64'(ev));
    check({tag, "_addr"}, 64'(bus.out_tex_addr), 64'(eaddr));
    release_out();
  endtask

  task automatic setup_basic();
    clear_inputs();
    bus.in_tri_area = 100; bus.in_bary_w0 = 100;
    bus.in_v0_u = 7;       bus.in_v0_v = 9;
    bus.in_tex_width = 16'd64; bus.in_tex_height = 16'd64;
    bus.in_tex_base = 32'h1000; bus.in_tex_stride_bytes = 32'd256;
    bus.in_x = 32'h0012_0034; bus.in_y = 32'h0056_0078;
    bus.in_mask = 4'hA; bus.in_const_color_argb = 32'hCAFE_F00D;
  endtask

  task automatic start_quad();
    bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  initial begin
    bit seen;
    clear_inputs();
    repeat (3) @(negedge clk);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_out_u", 64'(bus.out_u), 64'd0);
    check("rst_out_addr", 64'(bus.out_tex_addr), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);

    // Basic clamp quad, pass-through and held output.
    setup_basic();
    accept_and_wait(lat);
    check("basic_lat", 64'(lat), 64'd20);
    check("basic_u", 64'(bus.out_u), 64'd7);
    check("basic_v", 64'(bus.out_v), 64'd9);
    check("basic_addr", 64'(bus.out_tex_addr), 64'h191C);
    check("basic_x", 64'(bus.out_x), 64'h0012_0034);
    check("basic_y", 64'(bus.out_y), 64'h0056_0078);
    check("basic_mask", 64'(bus.out_mask), 64'hA);
    check("basic_color", 64'(bus.out_const_color_argb), 64'hCAFE_F00D);
    check("basic_tex_en", 64'(bus.out_tex_enable), 64'd1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("hold_valid", 64'(bus.out_valid), 64'd1);
      check("hold_in_ready", 64'(bus.in_ready), 64'd0);
      check("hold_addr", 64'(bus.out_tex_addr), 64'h191C);
    end
    release_out();

    // Negative area and negative coordinate through the wrap modes.
    clear_inputs();
    bus.in_tri_area = -50; bus.in_bary_w0 = -50; bus.in_v0_u = -3;
    bus.in_tex_width = 16'd8; bus.in_tex_height = 16'd8;
    bus.in_tex_format = 2'd1; bus.in_tex_base = 32'h2000; bus.in_tex_stride_bytes = 32'd32;
    run_quad("neg_clamp", 16'd0, 16'd0, 32'h2000, 20);
    bus.in_wrap_u = 2'd1;
    run_quad("neg_repeat", 16'd5, 16'd0, 32'h200A, 20);
    bus.in_wrap_u = 2'd2;
`ifdef TEX_MIRROR_EN
    run_quad("neg_mirror", 16'd2, 16'd0, 32'h2004, 20);
`else
    run_quad("neg_mirror_off", 16'd0, 16'd0, 32'h2000, 20);
`endif

    // Zero area short-circuits the divider.
    clear_inputs();
    bus.in_bary_w0 = 3; bus.in_v0_u = 5; bus.in_v0_v = 6;
    bus.in_tex_width = 16'd64; bus.in_tex_height = 16'd64;
    bus.in_tex_base = 32'h3000; bus.in_tex_stride_bytes = 32'd64;
    run_quad("zero_area", 16'd0, 16'd0, 32'h3000, 4);

    // Saturating quotient, then clamp or repeat, I8 format.
    clear_inputs();
    bus.in_tri_area = 1; bus.in_bary_w0 = 32'sd1 <<< 20; bus.in_v0_u = 32'sd1 <<< 20;
    bus.in_tex_width = 16'd64; bus.in_tex_height = 16'd64;
    bus.in_tex_format = 2'd2; bus.in_tex_base = 32'h4000; bus.in_tex_stride_bytes = 32'd64;
    run_quad("sat_clamp", 16'd63, 16'd0, 32'h403F, 20);
    bus.in_wrap_u = 2'd1; bus.in_tex_width = 16'h8000;
    run_quad("sat_repeat", 16'h7FFF, 16'd0, 32'hBFFF, 20);

    // Three weights, truncation toward zero, clamp at width-1, repeat of a negative v.
    clear_inputs();
    bus.in_tri_area = 3;
    bus.in_bary_w0 = 1; bus.in_bary_w1 = 1; bus.in_bary_w2 = 1;
    bus.in_v0_u = 10; bus.in_v1_u = 20; bus.in_v2_u = 31;
    bus.in_v0_v = -1; bus.in_v1_v = -2; bus.in_v2_v = -4;
    bus.in_tex_width = 16'd16; bus.in_tex_height = 16'd16; bus.in_wrap_v = 2'd1;
    bus.in_tex_stride_bytes = 32'd100;
    run_quad("sum3", 16'd15, 16'd14, 32'd1460, 20);
    bus.in_tex_enable = 1'b0;
    run_quad("tex_off", 16'd15, 16'd14, 32'd0, 20);
    check("tex_off_flag", 64'(bus.out_tex_enable), 64'd0);

    // Both operands negative, reserved format uses 4-byte texels.
    clear_inputs();
    bus.in_tri_area = -4; bus.in_bary_w0 = -4; bus.in_v0_u = 9;
    bus.in_tex_width = 16'd16; bus.in_tex_height = 16'd16;
    bus.in_tex_format = 2'd3; bus.in_tex_base = 32'h100; bus.in_tex_stride_bytes = 32'd16;
    run_quad("negneg_fmt3", 16'd9, 16'd0, 32'h124, 20);

    // Flush during divide drops the quad.
    setup_basic();
    start_quad();
    repeat (4) @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy", 64'(busy), 64'd0);
    check("flush_in_ready", 64'(bus.in_ready), 64'd1);
    seen = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (bus.out_valid) seen = 1'b1;
    end
    check("flush_no_valid", 64'(seen), 64'd0);

    // Flush beats a simultaneous in_valid.
    bus.in_valid = 1'b1;
    flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    flush = 1'b0;
    check("flush_cap_busy", 64'(busy), 64'd0);
    check("flush_cap_in_ready", 64'(bus.in_ready), 64'd1);

    // Reset mid-divide clears the data outputs left from the previous quad.
    check("pre_rst_u", 64'(bus.out_u), 64'd9);
    start_quad();
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("midrst_u", 64'(bus.out_u), 64'd0);
    check("midrst_addr", 64'(bus.out_tex_addr), 64'd0);
    check("midrst_x", 64'(bus.out_x), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_valid", 64'(bus.out_valid), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_in_ready", 64'(bus.in_ready), 64'd1);
    setup_basic();
    run_quad("after_rst", 16'd7, 16'd9, 32'h191C, 20);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end
endmodule
